// File: rtl/band_scale_sched.sv
// band_scale_sched: time-multiplexed per-band gain scaling with a saturated sum into one audio sample
module band_scale_sched #(
    parameter int NUM_BANDS = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    smpl_vld,
    input  logic [16*NUM_BANDS-1:0] band_audio,
    input  logic [12*NUM_BANDS-1:0] band_pot,
    input  logic                    clr_ovr,
    output logic                    busy,
    output logic                    out_vld,
    output logic [15:0]             audio_out,
    output logic                    overrun
);
    localparam int IW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    typedef enum logic [1:0] {IDLE, SCALE, SAT} state_t;
    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic signed [18:0]      acc_q, acc_d;
    logic [16*NUM_BANDS-1:0] aud_q, aud_d;
    logic [12*NUM_BANDS-1:0] pot_q, pot_d;
    logic [15:0]             out_q, out_d;
    logic                    out_vld_q, out_vld_d;
    logic                    ovr_q, ovr_d;
    logic [11:0]             pot_sel;
    logic signed [15:0]      aud_sel;
    logic [23:0]             pot_sq;
    logic signed [28:0]      prod;
    logic [3:0]              prod_hi;
    logic [15:0]             scaled;
    logic signed [18:0]      acc_sum;
    logic [15:0]             acc_sat;
    // Single shared scaling datapath: squared-pot gain applied to the band at the current index
    always_comb begin
        pot_sel = pot_q[12*idx_q +: 12];
        aud_sel = $signed(aud_q[16*idx_q +: 16]);
        pot_sq  = {12'b0, pot_sel} * {12'b0, pot_sel};
        prod    = $signed({17'b0, pot_sq[23:12]}) * $signed({{13{aud_sel[15]}}, aud_sel});
        prod_hi = prod[28:25];
        scaled  = (prod_hi == 4'h0 || prod_hi == 4'hF) ? prod[25:10] : (prod[28] ? 16'h8000 : 16'h7FFF);
        acc_sum = acc_q + {{3{scaled[15]}}, scaled};
        acc_sat = (acc_q > 19'sd32767) ? 16'h7FFF : (acc_q < -19'sd32768) ? 16'h8000 : acc_q[15:0];
    end
    // Next-state, capture, accumulate and output-load logic; overrun set wins over clear
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        aud_d     = aud_q;
        pot_d     = pot_q;
        out_d     = out_q;
        out_vld_d = 1'b0;
        ovr_d     = (ovr_q & ~clr_ovr) | (smpl_vld & (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (smpl_vld) begin
                    aud_d   = band_audio;
                    pot_d   = band_pot;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = SCALE;
                end
            end
            SCALE: begin
                acc_d   = acc_sum;
                idx_d   = (idx_q == IW'(NUM_BANDS - 1)) ? idx_q : idx_q + 1'b1;
                state_d = (idx_q == IW'(NUM_BANDS - 1)) ? SAT : SCALE;
            end
            SAT: begin
                out_d     = acc_sat;
                out_vld_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            aud_q     <= '0;
            pot_q     <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            aud_q     <= aud_d;
            pot_q     <= pot_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            ovr_q     <= ovr_d;
        end
    end
    assign busy      = (state_q != IDLE);
    assign out_vld   = out_vld_q;
    assign audio_out = out_q;
    assign overrun   = ovr_q;
endmodule

// File: tb/tb_band_scale_sched.sv
// tb_band_scale_sched: directed vector table plus hand sequences for overrun, reset and back-to-back
module tb_band_scale_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        smpl_vld;
    logic [79:0] band_audio;
    logic [59:0] band_pot;
    logic        clr_ovr;
    logic        busy;
    logic        out_vld;
    logic [15:0] audio_out;
    logic        overrun;
    int checks = 0;
    int errors = 0;

    band_scale_sched #(.NUM_BANDS(5)) dut (
        .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld), .band_audio(band_audio),
        .band_pot(band_pot), .clr_ovr(clr_ovr), .busy(busy), .out_vld(out_vld),
        .audio_out(audio_out), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [79:0] aud;
        logic [59:0] pot;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input string n, input int a0, a1, a2, a3, a4,
                                input int p0, p1, p2, p3, p4, input logic [15:0] e);
        vec_t v;
        v.name = n;
        v.aud  = {16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
        v.pot  = {12'(p4), 12'(p3), 12'(p2), 12'(p1), 12'(p0)};
        v.exp  = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge with inputs scrambled
    task automatic start(input vec_t v);
        band_audio = v.aud;
        band_pot   = v.pot;
        smpl_vld   = 1'b1;
        @(posedge clk);
        #1;
        smpl_vld   = 1'b0;
        band_audio = ~v.aud;
        band_pot   = ~v.pot;
        chk({v.name, " busy_after_accept"}, 32'(busy), 32'd1);
    endtask

    // Edge k counts from the accepting edge; result is due on edge 6
    task automatic wait_result(input logic [15:0] exp, input string name, input int k0);
        logic early = 1'b0;
        for (int k = k0; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (k < 6 && (out_vld || !busy)) early = 1'b1;
        end
        chk({name, " latency"}, 32'(early), 32'd0);
        chk({name, " out_vld"}, 32'(out_vld), 32'd1);
        chk({name, " audio_out"}, 32'(audio_out), 32'(exp));
        chk({name, " busy_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk({name, " out_vld_one_cycle"}, 32'(out_vld), 32'd0);
        chk({name, " audio_hold"}, 32'(audio_out), 32'(exp));
    endtask

    initial begin
        vec_t unity, mixed;
        logic seen;
        unity   = mk("unity", 1000, 2000, -500, 0, 7, 'h800, 'h800, 'h800, 'h800, 'h800, 16'd2507);
        mixed   = mk("mixed", 1000, -3, 5000, 100, -2000, 'h400, 'h800, 'h000, 'hFFF, 'h200, 16'h0209);
        vecs[0] = unity;
        vecs[1] = mk("sum_sat_pos", 'h7000, 'h7000, 'h7000, 'h7000, 'h7000, 'h800, 'h800, 'h800, 'h800, 'h800, 16'h7FFF);
        vecs[2] = mk("sum_sat_neg", 'h9000, 'h9000, 'h9000, 'h9000, 'h9000, 'h800, 'h800, 'h800, 'h800, 'h800, 16'h8000);
        vecs[3] = mk("band_sat_pos", 'h4000, 1234, -999, 77, 'h7FFF, 'hFFF, 0, 0, 0, 0, 16'h7FFF);
        vecs[4] = mk("band_sat_neg", -16384, 1234, -999, 77, 'h7FFF, 'hFFF, 0, 0, 0, 0, 16'h8000);
        vecs[5] = mk("minus_one", -1, 50, 50, 50, 50, 'h800, 0, 0, 0, 0, 16'hFFFF);
        vecs[6] = mixed;
        vecs[7] = mk("floor_trunc", -3, 0, 0, 0, 0, 'h400, 0, 0, 0, 0, 16'hFFFF);

        rst_n = 1'b0; smpl_vld = 1'b0; clr_ovr = 1'b0; band_audio = '0; band_pot = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 0);
        chk("reset out_vld", 32'(out_vld), 0);
        chk("reset audio_out", 32'(audio_out), 0);
        chk("reset overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            start(vecs[i]);
            wait_result(vecs[i].exp, vecs[i].name, 1);
        end
        chk("table overrun", 32'(overrun), 0);

        start(unity);
        @(posedge clk);
        #1;
        band_audio = '1;
        smpl_vld   = 1'b1;
        @(posedge clk);
        #1;
        smpl_vld = 1'b0;
        chk("ovr set", 32'(overrun), 1);
        wait_result(16'd2507, "ovr_first", 3);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (out_vld) seen = 1'b1;
        end
        chk("ovr single_pulse", 32'(seen), 0);
        chk("ovr sticky", 32'(overrun), 1);
        clr_ovr = 1'b1;
        @(posedge clk);
        #1;
        clr_ovr = 1'b0;
        chk("ovr cleared", 32'(overrun), 0);

        start(mixed);
        smpl_vld = 1'b1;
        @(posedge clk);
        #1;
        clr_ovr = 1'b1;
        @(posedge clk);
        #1;
        smpl_vld = 1'b0;
        clr_ovr  = 1'b0;
        chk("ovr set_beats_clear", 32'(overrun), 1);
        wait_result(16'h0209, "ovr_coincide", 3);

        start(mixed);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 0);
        chk("midrst out_vld", 32'(out_vld), 0);
        chk("midrst audio_out", 32'(audio_out), 0);
        chk("midrst overrun", 32'(overrun), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (out_vld || busy) seen = 1'b1;
        end
        chk("midrst no_pulse", 32'(seen), 0);
        start(unity);
        wait_result(16'd2507, "post_reset", 1);

        start(mixed);
        repeat (6) @(posedge clk);
        #1;
        chk("b2b first_vld", 32'(out_vld), 1);
        chk("b2b first_val", 32'(audio_out), 32'h0209);
        start(unity);
        wait_result(16'd2507, "b2b_second", 1);
        chk("b2b overrun", 32'(overrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
